// File: rtl/irq_pkg.sv
// Shared definitions for irq_ctrl: FSM state type, cause-register field layout,
// interrupt-line limit and the fixed-priority selector.
package irq_pkg;

    localparam int unsigned N_IRQ_MAX     = 8;
    localparam logic [4:0]  EXCCODE_INT   = 5'd0;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_SID_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_e;

    // Lowest set index wins; returns 0 for an all-zero vector.
    function automatic logic [2:0] prio_sel(input logic [N_IRQ_MAX-1:0] v);
        logic found;
        prio_sel = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_IRQ_MAX; i++) begin
            if (v[i] && !found) begin
                prio_sel = 3'(i);
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line 2-flop synchronizer followed by a single-cycle rising-edge detector.
// Used by irq_ctrl only when IRQ_EDGE_DET_EN is defined.
module irq_edge_sync
    import irq_pkg::*;
#(
    parameter int unsigned N = N_IRQ_MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq,
    output logic [N-1:0] rise
);

    logic [N-1:0] sync1, sync2, prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with IDLE/REQ/SERV handshake to the CPU.
// Define IRQ_EDGE_DET_EN for synchronised rising-edge events; default is level-sensitive.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic [31:0]      sta,
    input  logic             inta,
    input  logic             eret,
    output logic             intr,
    output logic [2:0]       irq_id,
    output logic             busy,
    output logic [31:0]      cause
);

    state_e               state;
    logic [N_IRQ-1:0]     ev, pend, pend_n;
    logic [N_IRQ_MAX-1:0] pend_ext, elig, clr;
    logic [2:0]           sel, served_id;
    logic                 ack;
    logic                 unused_sta;

`ifdef IRQ_EDGE_DET_EN
    irq_edge_sync #(.N(N_IRQ)) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .rise (ev)
    );
`else
    assign ev = irq;
`endif

    assign unused_sta = ^{sta[31:16], sta[7:1]};

    // Clearing uses the offered irq_id; a same-cycle event on that line re-sets it.
    always_comb begin
        pend_ext            = '0;
        pend_ext[N_IRQ-1:0] = pend;
        elig                = sta[0] ? (pend_ext & sta[15:8]) : '0;
        sel                 = prio_sel(elig);
        ack                 = (state == ST_REQ) && inta;
        clr                 = '0;
        if (ack) clr[irq_id] = 1'b1;
        pend_n = (pend & ~clr[N_IRQ-1:0]) | ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            served_id <= '0;
            intr      <= 1'b0;
            irq_id    <= '0;
        end else begin
            pend <= pend_n;
            case (state)
                ST_IDLE: begin
                    if (elig != '0) begin
                        state  <= ST_REQ;
                        intr   <= 1'b1;
                        irq_id <= sel;
                    end
                end
                ST_REQ: begin
                    if (inta) begin
                        state     <= ST_SERV;
                        served_id <= irq_id;
                        intr      <= 1'b0;
                    end else if (elig == '0) begin
                        state <= ST_IDLE;
                        intr  <= 1'b0;
                    end else begin
                        irq_id <= sel;
                    end
                end
                ST_SERV: begin
                    if (eret) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == ST_SERV);

    always_comb begin
        cause                           = '0;
        cause[CAUSE_EXC_LSB +: 5]       = EXCCODE_INT;
        cause[CAUSE_IP_LSB +: 8]        = pend_ext;
        cause[CAUSE_SID_LSB +: 3]       = served_id;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic, checked
// against a behavioural model; follows IRQ_EDGE_DET_EN like the design.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic [31:0] sta;
    logic        inta, eret;
    logic        intr, busy;
    logic [2:0]  irq_id;
    logic [31:0] cause;

    irq_ctrl #(.N_IRQ(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .sta    (sta),
        .inta   (inta),
        .eret   (eret),
        .intr   (intr),
        .irq_id (irq_id),
        .busy   (busy),
        .cause  (cause)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    typedef struct {
        int          cyc;
        bit          intr;
        bit [2:0]    id;
        bit          busy;
        bit [31:0]   cause;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_cnt, act, want);
        end
    endtask

    // Behavioural model: "offer" = an interrupt currently presented to the CPU,
    // "in_service" = acknowledged and waiting for eret.
    bit [7:0] m_pend;
    bit       m_offer, m_in_service;
    int       m_id, m_served;
    bit [7:0] m_hist [3];   // irq seen 1, 2 and 3 edges ago

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge(input bit [7:0] i_v, input bit [31:0] s_v,
                              input bit a_v, input bit e_v, input bit r_v);
        bit [7:0] elig, ev, cleared;
        exp_t     e;
        if (!r_v) begin
            m_pend = 0; m_offer = 0; m_in_service = 0; m_id = 0; m_served = 0;
            foreach (m_hist[k]) m_hist[k] = 0;
        end else begin
            elig    = s_v[0] ? (m_pend & s_v[15:8]) : 8'h00;
`ifdef IRQ_EDGE_DET_EN
            ev = m_hist[1] & ~m_hist[2];
`else
            ev = i_v;
`endif
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = i_v;
            cleared = 8'h00;
            if (m_in_service) begin
                if (e_v) m_in_service = 0;
            end else if (m_offer) begin
                if (a_v) begin
                    cleared[m_id] = 1'b1;
                    m_served      = m_id;
                    m_offer       = 0;
                    m_in_service  = 1;
                end else if (elig == 0) begin
                    m_offer = 0;
                end else begin
                    m_id = lowest(elig);
                end
            end else if (elig != 0) begin
                m_offer = 1;
                m_id    = lowest(elig);
            end
            m_pend = (m_pend & ~cleared) | ev;
        end
        e.cyc   = cyc_cnt + 1;
        e.intr  = m_offer;
        e.id    = 3'(m_id);
        e.busy  = m_in_service;
        e.cause = {13'h0, 3'(m_served), m_pend, 8'h00};
        q.push_back(e);
    endtask

    task automatic step(input bit [7:0] i_v, input bit [31:0] s_v,
                        input bit a_v, input bit e_v);
        irq = i_v; sta = s_v; inta = a_v; eret = e_v;
        model_edge(i_v, s_v, a_v, e_v, rst);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit [31:0] s_v);
        for (int i = 0; i < n; i++) step(8'h00, s_v, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                e = q.pop_front();
                chk("intr",   {31'h0, intr},   {31'h0, e.intr});
                chk("irq_id", {29'h0, irq_id}, {29'h0, e.id});
                chk("busy",   {31'h0, busy},   {31'h0, e.busy});
                chk("cause",  cause,           e.cause);
            end
        end
    end

    initial begin : driver
        bit [7:0]  cur_irq;
        bit [31:0] cur_sta;
        rst = 1'b0; irq = '0; sta = '0; inta = 1'b0; eret = 1'b0;
        idle(3, 32'h0000_FF01);
        rst = 1'b1;

        // Single request on line 2, then higher-priority line 0 preempts the offer
        for (int i = 0; i < 4; i++) step(8'h04, 32'h0000_FF01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h05, 32'h0000_FF01, 1'b0, 1'b0);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);
        idle(4, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b0, 1'b1);
        idle(3, 32'h0000_FF01);

        // IE dropped while offering: withdrawal, then re-assertion
        idle(3, 32'h0000_FF00);
        idle(3, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);

        // Event during service, stray inta in service, then eret
        step(8'h20, 32'h0000_FF01, 1'b0, 1'b0);
        idle(3, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);
        step(8'h00, 32'h0000_FF01, 1'b0, 1'b1);
        idle(4, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);
        step(8'h00, 32'h0000_FF01, 1'b0, 1'b1);
        idle(3, 32'h0000_FF01);

        // Line 3 held high for 20 cycles with acknowledge/eret traffic
        for (int i = 0; i < 20; i++)
            step(8'h08, 32'h0000_FF01, (i % 6) == 4, (i % 6) == 5);
        idle(6, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);
        step(8'h00, 32'h0000_FF01, 1'b0, 1'b1);
        idle(3, 32'h0000_FF01);

        // Reach service with 0x30 pending, then reset asynchronously
        step(8'h01, 32'h0000_FF01, 1'b0, 1'b0);
        idle(4, 32'h0000_FF01);
        step(8'h00, 32'h0000_FF01, 1'b1, 1'b0);
        step(8'h30, 32'h0000_FF01, 1'b0, 1'b0);
        idle(4, 32'h0000_FF01);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_intr",   {31'h0, intr},   32'h0);
        chk("async_irq_id", {29'h0, irq_id}, 32'h0);
        chk("async_busy",   {31'h0, busy},   32'h0);
        chk("async_cause",  cause,           32'h0);
        idle(2, 32'h0000_FF01);
        rst = 1'b1;
        idle(6, 32'h0000_FF01);

        // Randomized traffic
        cur_irq = 8'h00;
        cur_sta = 32'h0000_FF01;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                cur_irq = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                cur_sta = {$urandom} & 32'hFFFF_FFFE
                          | {16'h0, 8'($urandom) | 8'($urandom), 8'h00}
                          | {31'h0, $urandom_range(0, 7) != 0};
            step(cur_irq, cur_sta, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        idle(8, 32'h0000_FF01);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
